// File: rtl/iccm_loader_pkg.sv
// Shared types and global memory/core widths for the ICCM boot loader.
// The CHECK state exists only when LOADER_CHECKSUM_EN is defined.
package iccm_loader_pkg;

    localparam int XLEN                 = 32;
    localparam int INSTR_MEM_WIDTH      = 32;
    localparam int INSTR_MEM_DEPTH      = 1024;
    localparam int INSTR_MEM_ADDR_WIDTH = $clog2(INSTR_MEM_DEPTH);

    localparam logic [31:0] LOADER_MAGIC = 32'h5456_4C44;

    typedef enum logic [2:0] {
        HDR_MAGIC = 3'd0,
        HDR_ENTRY = 3'd1,
        HDR_LEN   = 3'd2,
        LOAD      = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        CHECK     = 3'd4,
`endif
        DONE      = 3'd5,
        ERROR     = 3'd6
    } loader_state_t;

endpackage

// File: rtl/iccm_loader_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_valid pulses
// for one cycle on the cycle after the 4th byte of each word is accepted.
module byte_packer (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  byte_data,
    input  logic        byte_en,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  byte_cnt;
    logic [23:0] shift;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_cnt   <= 2'd0;
            shift      <= 24'd0;
            word       <= 32'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (byte_en) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    word       <= {byte_data, shift};
                    word_valid <= 1'b1;
                end else begin
                    // earliest byte drifts down to bits [7:0]
                    shift <= {byte_data, shift[23:8]};
                end
            end
        end
    end

endmodule

// File: rtl/iccm_loader.sv
// Boot loader: parses magic/entry/length header from a byte stream, writes the
// image into ICCM, then releases core reset. Optional macro: LOADER_CHECKSUM_EN.
//
// state     | meaning
// HDR_MAGIC | waiting for header magic word
// HDR_ENTRY | waiting for entry PC word
// HDR_LEN   | waiting for image length N (words)
// LOAD      | writing data words 0..N-1 to ICCM
// CHECK     | comparing received sum word (LOADER_CHECKSUM_EN only)
// DONE      | image accepted, core released (terminal)
// ERROR     | image rejected, core held in reset (terminal)
module iccm_loader
    import iccm_loader_pkg::*;
#(
    parameter logic [31:0] MAGIC     = LOADER_MAGIC,
    parameter int          MAX_WORDS = INSTR_MEM_DEPTH
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_valid,
    output logic                            rx_ready,
    output logic [INSTR_MEM_ADDR_WIDTH-1:0] iccm_waddr,
    output logic [INSTR_MEM_WIDTH-1:0]      iccm_wdata,
    output logic                            iccm_wen,
    output logic                            core_rstn,
    output logic [XLEN-1:0]                 reset_vector,
    output logic                            load_done,
    output logic                            load_error
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    loader_state_t    state_q, state_d;
    logic [31:0]      word;
    logic             word_valid;
    logic [CNT_W-1:0] widx_q;
    logic [CNT_W-1:0] n_words_q;
    logic             latch_entry;
    logic             latch_len;
    logic             write_en;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]      csum_q;
`endif

    byte_packer u_packer (
        .clk        (clk),
        .rstn       (rstn),
        .byte_data  (rx_data),
        .byte_en    (rx_valid && rx_ready),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_d     = state_q;
        latch_entry = 1'b0;
        latch_len   = 1'b0;
        write_en    = 1'b0;
        case (state_q)
            HDR_MAGIC: if (word_valid) begin
                if (word == MAGIC) state_d = HDR_ENTRY;
                else               state_d = ERROR;
            end
            HDR_ENTRY: if (word_valid) begin
                latch_entry = 1'b1;
                state_d     = HDR_LEN;
            end
            HDR_LEN: if (word_valid) begin
                if (word == 32'd0 || word > 32'(MAX_WORDS)) begin
                    state_d = ERROR;
                end else begin
                    latch_len = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: if (word_valid) begin
                write_en = 1'b1;
                if (widx_q == n_words_q - CNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: if (word_valid) begin
                if (word == csum_q) state_d = DONE;
                else                state_d = ERROR;
            end
`endif
            default: ;
        endcase
    end

    // Status outputs are registered from the next state so they change on the
    // same edge as the state and never glitch.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= HDR_MAGIC;
            widx_q       <= '0;
            n_words_q    <= '0;
            reset_vector <= '0;
            rx_ready     <= 1'b0;
            core_rstn    <= 1'b0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_ready   <= (state_d != DONE) && (state_d != ERROR);
            core_rstn  <= (state_d == DONE);
            load_done  <= (state_d == DONE);
            load_error <= (state_d == ERROR);
            if (latch_entry) reset_vector <= XLEN'(word);
            if (latch_len)   n_words_q    <= word[CNT_W-1:0];
            if (write_en)    widx_q       <= widx_q + CNT_W'(1);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)         csum_q <= 32'd0;
        else if (write_en) csum_q <= csum_q + word;
    end
`endif

    assign iccm_wen   = write_en;
    assign iccm_waddr = INSTR_MEM_ADDR_WIDTH'(widx_q);
    assign iccm_wdata = INSTR_MEM_WIDTH'(word);

endmodule

// File: tb/tb_iccm_loader.sv
// Directed bench for iccm_loader: header parsing, ICCM writes, terminal
// states, rx_valid gaps and mid-load reset.
module tb_iccm_loader;
    import iccm_loader_pkg::*;

    localparam int          MAXW  = 16;
    localparam logic [31:0] MAG   = 32'h5456_4C44;
    localparam logic [31:0] ENTRY = 32'h0000_0100;
    localparam logic [31:0] W0    = 32'h0000_0013;
    localparam logic [31:0] W1    = 32'hDEAD_BEEF;
    localparam logic [31:0] CSUM  = 32'hDEAD_BF02;

    logic                            clk = 1'b0;
    logic                            rstn = 1'b0;
    logic [7:0]                      rx_data = 8'd0;
    logic                            rx_valid = 1'b0;
    logic                            rx_ready;
    logic [INSTR_MEM_ADDR_WIDTH-1:0] iccm_waddr;
    logic [INSTR_MEM_WIDTH-1:0]      iccm_wdata;
    logic                            iccm_wen;
    logic                            core_rstn;
    logic [XLEN-1:0]                 reset_vector;
    logic                            load_done;
    logic                            load_error;

    int vectors = 0;
    int errors  = 0;
    int gap_k   = 0;
    int gap_tab [8] = '{0, 20, 1, 0, 5, 20, 0, 3};

    logic [31:0] wr_addr [256];
    logic [31:0] wr_data [256];
    int          wr_total = 0;

    always #5 clk = ~clk;

    iccm_loader #(.MAGIC(MAG), .MAX_WORDS(MAXW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .iccm_waddr   (iccm_waddr),
        .iccm_wdata   (iccm_wdata),
        .iccm_wen     (iccm_wen),
        .core_rstn    (core_rstn),
        .reset_vector (reset_vector),
        .load_done    (load_done),
        .load_error   (load_error)
    );

    always @(negedge clk) begin
        if (iccm_wen && wr_total < 256) begin
            wr_addr[wr_total] <= 32'(iccm_waddr);
            wr_data[wr_total] <= iccm_wdata;
            wr_total          <= wr_total + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gapped);
        int g;
        for (int i = 0; i < 4; i++) begin
            g = 0;
            if (gapped) begin
                g = gap_tab[gap_k % 8];
                if (gap_k % 3 == 2) g = g + int'($urandom_range(0, 4));
                gap_k++;
            end
            send_byte(w[8*i +: 8], g);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rstn     = 1'b0;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic send_image(input bit gapped);
        send_word(MAG, gapped);
        send_word(ENTRY, gapped);
        send_word(32'd2, gapped);
        send_word(W0, gapped);
        send_word(W1, gapped);
`ifdef LOADER_CHECKSUM_EN
        send_word(CSUM, gapped);
`endif
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({rx_ready, iccm_wen, core_rstn, load_done, load_error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {rx_ready, iccm_wen, core_rstn, load_done, load_error});
        end
        vectors++;
        if (reset_vector !== '0 || iccm_waddr !== '0 || iccm_wdata !== '0) begin
            errors++;
            $display("FAIL reset_buses: got rv=%h addr=%h data=%h expected 0",
                     reset_vector, iccm_waddr, iccm_wdata);
        end
        rstn = 1'b1;
        #1;
        vectors++;
        if (rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL rx_ready_before_edge: got %b expected 0", rx_ready);
        end
        @(negedge clk);
        vectors++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL rx_ready_after_release: got %b expected 1", rx_ready);
        end
    endtask

    task automatic test_good_load(input bit gapped, input string tag);
        int base;
        int w_cyc, d_cyc, c_cyc;
        apply_reset;
        base  = wr_total;
        gap_k = 0;
        w_cyc = -1;
        d_cyc = -1;
        c_cyc = -1;
        send_image(gapped);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            if (iccm_wen) w_cyc = i;
            if (load_done && d_cyc < 0) d_cyc = i;
            if (core_rstn && c_cyc < 0) c_cyc = i;
        end
        vectors++;
        if (wr_total - base !== 2) begin
            errors++;
            $display("FAIL %s_write_count: got %0d expected 2", tag, wr_total - base);
        end else begin
            vectors++;
            if (wr_addr[base] !== 32'd0 || wr_data[base] !== W0) begin
                errors++;
                $display("FAIL %s_write0: got addr=%0d data=%h expected addr=0 data=%h",
                         tag, wr_addr[base], wr_data[base], W0);
            end
            vectors++;
            if (wr_addr[base+1] !== 32'd1 || wr_data[base+1] !== W1) begin
                errors++;
                $display("FAIL %s_write1: got addr=%0d data=%h expected addr=1 data=%h",
                         tag, wr_addr[base+1], wr_data[base+1], W1);
            end
        end
        vectors++;
        if ({load_done, core_rstn, load_error, rx_ready} !== 4'b1100) begin
            errors++;
            $display("FAIL %s_status: got done/crst/err/rdy=%b expected 1100", tag,
                     {load_done, core_rstn, load_error, rx_ready});
        end
        vectors++;
        if (reset_vector !== XLEN'(ENTRY)) begin
            errors++;
            $display("FAIL %s_reset_vector: got %h expected %h", tag, reset_vector, ENTRY);
        end
        vectors++;
        if (c_cyc !== d_cyc || d_cyc < 0) begin
            errors++;
            $display("FAIL %s_done_edge: got core_rstn cycle %0d load_done cycle %0d expected equal",
                     tag, c_cyc, d_cyc);
        end
`ifndef LOADER_CHECKSUM_EN
        vectors++;
        if (d_cyc !== w_cyc + 1) begin
            errors++;
            $display("FAIL %s_last_write_timing: got done cycle %0d expected %0d",
                     tag, d_cyc, w_cyc + 1);
        end
`endif
    endtask

    task automatic test_bad_magic;
        int base;
        apply_reset;
        base = wr_total;
        send_word(32'h1234_5678, 1'b0);
        send_word(ENTRY, 1'b0);
        idle(4);
        vectors++;
        if ({load_error, rx_ready, core_rstn, load_done} !== 4'b1000) begin
            errors++;
            $display("FAIL bad_magic_status: got err/rdy/crst/done=%b expected 1000",
                     {load_error, rx_ready, core_rstn, load_done});
        end
        vectors++;
        if (wr_total !== base) begin
            errors++;
            $display("FAIL bad_magic_writes: got %0d expected 0", wr_total - base);
        end
    endtask

    task automatic test_bad_len(input logic [31:0] n, input string tag);
        int base;
        apply_reset;
        base = wr_total;
        send_word(MAG, 1'b0);
        send_word(ENTRY, 1'b0);
        send_word(n, 1'b0);
        idle(2);
        vectors++;
        if ({load_error, rx_ready, core_rstn} !== 3'b100) begin
            errors++;
            $display("FAIL %s_status: got err/rdy/crst=%b expected 100", tag,
                     {load_error, rx_ready, core_rstn});
        end
        send_word(W0, 1'b0);
        idle(3);
        vectors++;
        if (wr_total !== base) begin
            errors++;
            $display("FAIL %s_writes: got %0d expected 0", tag, wr_total - base);
        end
    endtask

    task automatic test_max_len;
        int          base;
        logic [31:0] w;
        logic [31:0] sum;
        apply_reset;
        base = wr_total;
        sum  = 32'd0;
        send_word(MAG, 1'b0);
        send_word(32'h0000_2000, 1'b0);
        send_word(32'(MAXW), 1'b0);
        for (int i = 0; i < MAXW; i++) begin
            w   = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
            sum = sum + w;
            send_word(w, 1'b0);
        end
`ifdef LOADER_CHECKSUM_EN
        send_word(sum, 1'b0);
`endif
        idle(4);
        vectors++;
        if (wr_total - base !== MAXW) begin
            errors++;
            $display("FAIL max_len_count: got %0d expected %0d", wr_total - base, MAXW);
        end else begin
            for (int i = 0; i < MAXW; i++) begin
                w = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
                vectors++;
                if (wr_addr[base+i] !== 32'(i) || wr_data[base+i] !== w) begin
                    errors++;
                    $display("FAIL max_len_word%0d: got addr=%0d data=%h expected addr=%0d data=%h",
                             i, wr_addr[base+i], wr_data[base+i], i, w);
                end
            end
        end
        vectors++;
        if ({load_done, core_rstn, load_error} !== 3'b110) begin
            errors++;
            $display("FAIL max_len_status: got done/crst/err=%b expected 110",
                     {load_done, core_rstn, load_error});
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_bad_checksum;
        int base;
        apply_reset;
        base = wr_total;
        send_word(MAG, 1'b0);
        send_word(ENTRY, 1'b0);
        send_word(32'd2, 1'b0);
        send_word(W0, 1'b0);
        send_word(W1, 1'b0);
        send_word(32'd0, 1'b0);
        idle(4);
        vectors++;
        if (wr_total - base !== 2) begin
            errors++;
            $display("FAIL bad_csum_writes: got %0d expected 2", wr_total - base);
        end
        vectors++;
        if ({load_error, core_rstn, load_done} !== 3'b100) begin
            errors++;
            $display("FAIL bad_csum_status: got err/crst/done=%b expected 100",
                     {load_error, core_rstn, load_done});
        end
    endtask
`endif

    task automatic test_midload_reset;
        int base;
        int n;
        apply_reset;
        base = wr_total;
        send_word(MAG, 1'b0);
        send_word(ENTRY, 1'b0);
        send_word(32'd2, 1'b0);
        send_word(W0, 1'b0);
        n = 0;
        while (wr_total == base && n < 20) begin
            idle(1);
            n++;
        end
        vectors++;
        if (wr_total - base !== 1) begin
            errors++;
            $display("FAIL midload_word0: got %0d writes expected 1", wr_total - base);
        end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        vectors++;
        if ({rx_ready, iccm_wen, core_rstn, load_done, load_error} !== 5'b0 ||
            reset_vector !== '0 || iccm_waddr !== '0 || iccm_wdata !== '0) begin
            errors++;
            $display("FAIL midload_reset_outputs: got flags=%b rv=%h addr=%h data=%h expected 0",
                     {rx_ready, iccm_wen, core_rstn, load_done, load_error},
                     reset_vector, iccm_waddr, iccm_wdata);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (rx_ready !== 1'b0 || iccm_wdata !== '0) begin
            errors++;
            $display("FAIL midload_reset_hold: got rdy=%b data=%h expected 0", rx_ready, iccm_wdata);
        end
        rstn = 1'b1;
        test_good_load(1'b0, "reload");
    endtask

    initial begin
        test_reset;
        test_good_load(1'b0, "basic");
        test_bad_magic;
        test_bad_len(32'd0, "len_zero");
        test_bad_len(32'(MAXW + 1), "len_over");
        test_max_len;
`ifdef LOADER_CHECKSUM_EN
        test_bad_checksum;
`endif
        test_good_load(1'b1, "gaps");
        test_midload_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/iccm_loader.md
ICCM_LOADER -- requirements
Module: iccm_loader

Interface
REQ-001 SHALL have parameter MAGIC, default 32'h5456_4C44, meaning the required header magic word.
REQ-002 SHALL have parameter MAX_WORDS, default INSTR_MEM_DEPTH, meaning the largest accepted image size in 32-bit words.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rx_data, input, 8 bits: image byte stream.
REQ-006 SHALL have port rx_valid, input, 1 bit: rx_data valid.
REQ-007 SHALL have port rx_ready, output, 1 bit: loader accepts a byte.
REQ-008 SHALL have port iccm_waddr, output, INSTR_MEM_ADDR_WIDTH bits: ICCM word index.
REQ-009 SHALL have port iccm_wdata, output, INSTR_MEM_WIDTH bits: ICCM write data.
REQ-010 SHALL have port iccm_wen, output, 1 bit: ICCM write strobe.
REQ-011 SHALL have port core_rstn, output, 1 bit: drives the rstn of core_top; low holds the core in reset.
REQ-012 SHALL have port reset_vector, output, XLEN bits: entry PC, drives the core_top reset_vector.
REQ-013 SHALL have ports load_done and load_error, outputs, 1 bit each: sticky status flags.

Function
REQ-014 SHALL count a byte as accepted only in a cycle where rx_valid and rx_ready are both high.
REQ-015 SHALL assemble every 4 accepted bytes into one word, little-endian: the first byte goes to bits [7:0].
REQ-016 SHALL implement the states HDR_MAGIC, HDR_ENTRY, HDR_LEN, LOAD, CHECK, DONE and ERROR.
REQ-017 SHALL apply these header rules:
  - HDR_MAGIC: a word equal to MAGIC goes to HDR_ENTRY; any other word goes to ERROR.
  - HDR_ENTRY: the word is latched into reset_vector; go to HDR_LEN.
  - HDR_LEN: the word is latched as N. N==0 or N>MAX_WORDS goes to ERROR; otherwise go to LOAD.
REQ-018 SHALL, in LOAD, on the 4th byte of data word k (k = 0..N-1):
  - on the next cycle, pulse iccm_wen for exactly one cycle with iccm_waddr=k and iccm_wdata=the word;
  - after word N-1, go to CHECK if LOADER_CHECKSUM_EN is defined, else to DONE.
REQ-019 SHALL hold rx_ready high in HDR_*, LOAD and CHECK, and low in DONE and ERROR.
REQ-020 SHALL make DONE and ERROR terminal: they are left only by rstn.
REQ-021 SHALL, on entering DONE, set load_done and core_rstn to 1 on the same edge, with core_rstn registered (glitch-free).
  - The write of the final word SHALL complete no later than that edge.
REQ-022 SHALL, on entering ERROR, set load_error to 1 while core_rstn stays 0.
REQ-023 SHALL keep the word-index counter wide enough for MAX_WORDS, with no wrap-around: N>MAX_WORDS is rejected in HDR_LEN.
REQ-024 SHALL tolerate rx_valid gaps of any length, including inside a word, with no timeout.

Reset
REQ-025 SHALL, while rstn is low, force these outputs, independent of clk:
  - rx_ready=0, iccm_wen=0, iccm_waddr=0, iccm_wdata=0;
  - core_rstn=0, reset_vector=0, load_done=0, load_error=0;
  - state=HDR_MAGIC, byte and word counters = 0.
REQ-026 SHALL abandon a load when rstn asserts mid-load, and restart from HDR_MAGIC after release; partly written ICCM contents are not cleared.
REQ-027 SHALL assert rx_ready 1 cycle after rstn deasserts.

Configuration
REQ-028 SHALL support the macro LOADER_CHECKSUM_EN:
  - When defined: accumulate a 32-bit modulo-2^32 sum of the N data words, and in CHECK compare one received word against it. Equal goes to DONE; unequal goes to ERROR.
  - When undefined: no CHECK state and no accumulator; after the last data word go straight to DONE.

Structure
REQ-029 SHALL place the state enum loader_state_t and the LOADER_MAGIC constant in the shared types package; INSTR_MEM_ADDR_WIDTH, INSTR_MEM_WIDTH and XLEN come from global definitions.
REQ-030 SHALL use one sub-module, byte_packer: byte counter, shift register and word_valid pulse. The FSM, counters and checksum stay in iccm_loader.
REQ-031 SHALL sit between the external byte source and the ICCM write port, with core_rstn and reset_vector wired to core_top.

Verification
REQ-032 SHALL pass: magic, entry 32'h0000_0100, N=2, words 32'h0000_0013 and 32'hDEAD_BEEF (checksum 32'hDEAD_BF02 when enabled) -> two iccm_wen pulses at addresses 0 and 1; then load_done=1, core_rstn=1, reset_vector=32'h100.
REQ-033 SHALL pass: first word 32'h1234_5678 -> load_error=1, rx_ready=0, core_rstn stays 0, and no iccm_wen.
REQ-034 SHALL pass: N=0, and separately N=MAX_WORDS+1 -> ERROR right after HDR_LEN, with no iccm_wen.
REQ-035 SHALL pass, with LOADER_CHECKSUM_EN defined: case REQ-032 with checksum 32'h0 -> both writes occur, load_error=1, core_rstn=0.
REQ-036 SHALL pass: random rx_valid gaps, including 0 and 20-cycle gaps inside words -> identical write sequence to REQ-032.
REQ-037 SHALL pass: rstn pulsed low after word 0 is written -> all outputs are at reset values during the pulse; a full reload then succeeds.
